issue_sel: RTL
==============

# issue_sel

Dual-issue selection and issue-register stage for the dual-issue scalar core. It sits between the two decoders, which are fed from the instruction buffer, and the execute stage. Each cycle it decides whether to issue zero, one or both decoded instructions in program order, and tells the instruction buffer how many slots were consumed. It holds the issued pair in a registered hand-off to execute and tracks outstanding load destinations in a scoreboard.

## Interface
- INST_W, 32, width of the instruction payload carried to execute
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- s0_valid  in  1  slot 0 (older instruction) is present
- s0_inst  in  INST_W  slot 0 instruction payload
- s0_dec  in  20  slot 0 decode info, packed {cls[1:0], wen, use_rs2, use_rs1, rs2[4:0], rs1[4:0], rd[4:0]}
  - cls encoding: 00 ALU, 01 load, 10 store, 11 branch/jump
- s1_valid  in  1  slot 1 (younger instruction) is present
- s1_inst  in  INST_W  slot 1 instruction payload
- s1_dec  in  20  slot 1 decode info, same packing as s0_dec
- ex_ready  in  1  execute accepts the current issue register contents this cycle
- flush  in  1  redirect from execute; discard everything not yet accepted
- wb_valid  in  1  a load result is written back this cycle
- wb_rd  in  5  destination register of that load
- buf_pop  out  2  slots consumed this cycle (0, 1 or 2); combinational
- iss0_valid  out  1  issue register slot 0 valid
- iss0_inst  out  INST_W  issue register slot 0 payload
- iss1_valid  out  1  issue register slot 1 valid
- iss1_inst  out  INST_W  issue register slot 1 payload
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- **States:**
  - IDLE is the reset state and always moves to RUN on the next cycle.
  - RUN moves to FLUSH when flush=1.
  - FLUSH always moves to RUN on the next cycle. If flush=1 while in FLUSH, stay in FLUSH.
  - No issue happens in IDLE or FLUSH.
- **Advance:** adv = ex_ready | ~iss0_valid.
- **Scoreboard:** sb[31:0] is registered; bit 0 is hard-wired 0.
- **hit(s):** true if either of the following holds.
  - A used source register is pending: (use_rs1 & sb[rs1]) | (use_rs2 & sb[rs2]).
  - A write-after-write conflict with an outstanding load: wen & sb[rd].
- **Slot 0 issues (go0)** when all of these hold: state=RUN, ~flush, adv, s0_valid, ~hit(s0).
- **Slot 1 issues (go1)** when go0 and s1_valid and ~hit(s1), and none of the following apply.
  - s0 is a branch/jump (cls=11).
  - Both slots are memory ops (cls 01 or 10).
  - Read-after-write: s0 writes (wen=1) a nonzero rd that s1 uses as rs1 or rs2.
  - Write-after-write: both slots write (wen=1) the same nonzero rd.
- **Buffer pop:** buf_pop = go0 + go1.
- **Issue register update:**
  - If flush=1: clear iss0_valid and iss1_valid.
  - Else if adv: load iss0_valid=go0 and iss1_valid=go1, and capture the payloads.
  - Otherwise: hold all fields.
- **Scoreboard update, per cycle:**
  - Set sb[rd] for each issued load (cls=01) with wen=1 and rd≠0.
  - Clear sb[wb_rd] when wb_valid=1.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - flush does not modify the scoreboard, because loads already in flight still write back.
- **Stall counter:** stall_cnt increments when state=RUN, s0_valid=1 and go0=0, whatever the cause. It saturates at 0xFFFF.

## Timing
- **Reset values:**
  - state=IDLE; iss0_valid=0 and iss1_valid=0.
  - iss0_inst=0 and iss1_inst=0; sb=0; stall_cnt=0.
  - buf_pop=0, because state is not RUN.
- **Latency:** an instruction presented in cycle N with go=1 appears on iss*_valid in cycle N+1. buf_pop is asserted in cycle N.
- **Scoreboard timing:** checks use registered sb only, with no wb bypass.
  - A consumer of a load whose wb_valid arrives in cycle M can issue in cycle M+1 at the earliest.
  - A load issued in cycle N marks sb visible to the checks in cycle N+1.
  - Slot 1 in the same pair as the load is covered by the RAW and WAW rules.
- **Back-pressure:** while ex_ready=0 with a valid issue register, buf_pop=0 and the iss* outputs are stable.
- **Flush:**
  - In the flush cycle, buf_pop=0.
  - In the following cycle, iss*_valid=0 and state=FLUSH, with buf_pop=0 again.
  - Issue resumes at the earliest one cycle later.
- **Invariant:** iss1_valid is never 1 while iss0_valid is 0.

## Test plan
- **Independent ALU pair.** Stimulus: s0 = add x1,x2,x3 and s1 = add x4,x5,x6, ex_ready=1, state RUN. Required: buf_pop=2, and the next cycle has iss0_valid=1, iss1_valid=1 with matching payloads.
- **Intra-pair RAW.** Stimulus: s0 writes x5 and s1 reads x5 as rs2. Required: buf_pop=1 and iss1_valid=0. The following cycle the former s1, now presented as s0, issues.
- **Load-use.**
  - Stimulus: a load to x7 issues in cycle N, and a consumer of x7 then waits in s0.
  - Required while waiting: buf_pop=0 and stall_cnt increments each cycle until wb_valid=1, wb_rd=7 in cycle M.
  - Required: the consumer issues in M+1 and sb[7]=0 from M+1.
- **Structural conflicts.** Stimulus A: load in s0, store in s1. Stimulus B: branch in s0, ALU op in s1. Required for both: buf_pop=1.
- **Back-pressure, then flush.**
  - Stimulus: ex_ready=0 with iss valid for 3 cycles. Required: outputs held and buf_pop=0.
  - Stimulus: then flush=1. Required: iss valids are 0 next cycle, no issue in the FLUSH cycle, and sb is unchanged.
- **Reset mid-operation.** Stimulus: assert reset while sb≠0 and iss valid. Required: immediately all outputs 0, sb=0 and stall_cnt=0. After release, one IDLE cycle with buf_pop=0 before any issue.

Source files
------------

// File: rtl/issue_sel.sv
// Dual-issue selector: picks 0/1/2 in-order instructions per cycle, registers them
// for execute, and tracks pending load destinations in a scoreboard.
module issue_sel #(
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s0_valid,
   input  logic [INST_W-1:0] s0_inst,
   input  logic [19:0]       s0_dec,
   input  logic              s1_valid,
   input  logic [INST_W-1:0] s1_inst,
   input  logic [19:0]       s1_dec,
   input  logic              ex_ready,
   input  logic              flush,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   output logic [1:0]        buf_pop,
   output logic              iss0_valid,
   output logic [INST_W-1:0] iss0_inst,
   output logic              iss1_valid,
   output logic [INST_W-1:0] iss1_inst,
   output logic [15:0]       stall_cnt,
   output logic [1:0]        dbg_state,
   output logic [31:0]       dbg_sb
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] sb, sb_set, sb_clr, sb_nxt;
   logic        adv, go0, go1, run;
   logic        mem0, mem1, raw, waw;

   // dec fields: [19:18] cls, [17] wen, [16] use_rs2, [15] use_rs1,
   // [14:10] rs2, [9:5] rs1, [4:0] rd
   function automatic logic hit(input logic [19:0] d, input logic [31:0] s);
      return (d[15] & s[d[9:5]]) | (d[16] & s[d[14:10]]) | (d[17] & s[d[4:0]]);
   endfunction

   // Handshake: the issue register is the valid side (iss0_valid/iss1_valid),
   // ex_ready is the ready side; contents transfer on a cycle where both are 1
   // and are held unchanged while valid is 1 and ready is 0.
   assign run  = (state == RUN);
   assign adv  = ex_ready | ~iss0_valid;
   assign mem0 = (s0_dec[19:18] == 2'b01) | (s0_dec[19:18] == 2'b10);
   assign mem1 = (s1_dec[19:18] == 2'b01) | (s1_dec[19:18] == 2'b10);
   assign raw  = s0_dec[17] & (s0_dec[4:0] != 5'd0) &
                 ((s1_dec[15] & (s1_dec[9:5] == s0_dec[4:0])) |
                  (s1_dec[16] & (s1_dec[14:10] == s0_dec[4:0])));
   assign waw  = s0_dec[17] & s1_dec[17] & (s0_dec[4:0] != 5'd0) &
                 (s0_dec[4:0] == s1_dec[4:0]);

   assign go0 = run & ~flush & adv & s0_valid & ~hit(s0_dec, sb);
   assign go1 = go0 & s1_valid & ~hit(s1_dec, sb) & (s0_dec[19:18] != 2'b11) &
                ~(mem0 & mem1) & ~raw & ~waw;

   assign buf_pop   = {1'b0, go0} + {1'b0, go1};
   assign dbg_state = state;
   assign dbg_sb    = sb;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   state_nxt = flush ? FLUSH : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // A load issuing in the same cycle as a writeback to the same register keeps it pending.
   always_comb begin
      sb_set = '0;
      sb_clr = '0;
      if (wb_valid) sb_clr[wb_rd] = 1'b1;
      if (go0 && s0_dec[19:18] == 2'b01 && s0_dec[17] && s0_dec[4:0] != 5'd0)
         sb_set[s0_dec[4:0]] = 1'b1;
      if (go1 && s1_dec[19:18] == 2'b01 && s1_dec[17] && s1_dec[4:0] != 5'd0)
         sb_set[s1_dec[4:0]] = 1'b1;
      sb_nxt = ((sb & ~sb_clr) | sb_set) & ~32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sb         <= '0;
         iss0_valid <= 1'b0;
         iss1_valid <= 1'b0;
         iss0_inst  <= '0;
         iss1_inst  <= '0;
         stall_cnt  <= '0;
      end else begin
         state <= state_nxt;
         sb    <= sb_nxt;
         if (flush) begin
            iss0_valid <= 1'b0;
            iss1_valid <= 1'b0;
         end else if (adv) begin
            iss0_valid <= go0;
            iss1_valid <= go1;
            iss0_inst  <= s0_inst;
            iss1_inst  <= s1_inst;
         end
         if (run && s0_valid && !go0 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
